// File: rtl/corr_pkg.sv
// rtl/corr_pkg.sv - shared constants, state encoding and helpers for the correlator bank dump
package corr_pkg;

    // Bank select values carried in RamAddr[15:12]
    localparam logic [3:0] BANK_A = 4'd1;
    localparam logic [3:0] BANK_B = 4'd2;
    localparam logic [3:0] BANK_C = 4'd3;
    localparam logic [3:0] BANK_D = 4'd4;
    localparam logic [3:0] BANK_E = 4'd5;

    // Word count of bank A; each following bank doubles
    localparam int BASE_LEN = 32;

    // Top byte of every bank header word
    localparam logic [7:0] HDR_TAG = 8'hC0;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        HDR,
        RD,
        OUT,
        FIN
    } dumpState_e;

    // Word count of a 1-based bank: baseLen << (bank-1)
    function automatic logic [15:0] bankLen(input int baseLen, input logic [3:0] bank);
        int shifted;
        shifted = baseLen << (bank - 4'd1);
        return shifted[15:0];
    endfunction

    // Header word announcing a bank and its length
    function automatic logic [31:0] hdrWord(input logic [3:0] bank, input logic [15:0] len);
        return {HDR_TAG, bank, 4'h0, len};
    endfunction

endpackage

// File: rtl/corr_rd_wait.sv
// rtl/corr_rd_wait.sv - read latency counter producing a capture strobe
module corr_rd_wait #(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic capture
);

    logic [2:0] cnt;
    logic       active;

    // The strobe fires once the address has been held for RD_LATENCY+1 cycles
    assign capture = active && (cnt == 3'd0);

    // Load on go (the cycle the new address is registered), then count down
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= 3'd0;
        end else if (go) begin
            active <= 1'b1;
            cnt    <= 3'(RD_LATENCY);
        end else if (capture) begin
            active <= 1'b0;
        end else if (active) begin
            cnt <= cnt - 3'd1;
        end
    end

endmodule

// File: rtl/corr_bank_dump.sv
// rtl/corr_bank_dump.sv - walks the correlator banks and streams headers and words
module corr_bank_dump #(
    parameter int RD_LATENCY = 1,
    parameter int NUM_BANKS  = 5,
    parameter int BASE_LEN   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_BANKS-1:0] bank_mask,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          RamAddr,
    input  logic [31:0]          RamData,
    output logic [31:0]          tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 tx_last
);
    import corr_pkg::*;

    dumpState_e           state;
    logic [NUM_BANKS-1:0] pending;
    logic [3:0]           bank;
    logic [9:0]           index;

    logic [15:0]          curLen;
    logic [3:0]           nextBank;
    logic [NUM_BANKS-1:0] bankOneHot;
    logic [NUM_BANKS-1:0] otherPending;
    logic                 anyPending;
    logic                 lastIdx;
    logic                 lastBank;
    logic                 hsHdr;
    logic                 hsOut;
    logic                 goRd;
    logic                 captureStb;

    assign curLen       = bankLen(BASE_LEN, bank);
    assign lastIdx      = ({6'd0, index} == (curLen - 16'd1));
    assign otherPending = pending & ~bankOneHot;
    assign lastBank     = (otherPending == '0);
    assign anyPending   = |pending;
    assign hsHdr        = (state == HDR) && tx_valid && tx_ready;
    assign hsOut        = (state == OUT) && tx_valid && tx_ready;
    assign goRd         = hsHdr || (hsOut && !lastIdx);

    // Lowest pending bank, scanning down so the lowest set bit wins
    always_comb begin
        nextBank = 4'd0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                nextBank = 4'(i + 1);
            end
        end
    end

    // One-hot of the bank currently being dumped, used to retire it from pending
    always_comb begin
        bankOneHot = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            bankOneHot[i] = (bank == 4'(i + 1));
        end
    end

    corr_rd_wait #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_wait (
        .clk    (clk),
        .rst    (rst),
        .go     (goRd),
        .capture(captureStb)
    );

    // Dump sequencer; every output is registered on entry to the state that owns it
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            bank     <= 4'd0;
            index    <= 10'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            RamAddr  <= 16'h0000;
            tx_data  <= 32'd0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pending <= bank_mask;
                        bank    <= BANK_A;
                        busy    <= 1'b1;
                        if (bank_mask == '0) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            state <= SEL;
                        end
                    end
                end
                SEL: begin
                    if (anyPending) begin
                        bank     <= nextBank;
                        tx_data  <= hdrWord(nextBank, bankLen(BASE_LEN, nextBank));
                        tx_valid <= 1'b1;
                        tx_last  <= 1'b0;
                        state    <= HDR;
                    end else begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                HDR: begin
                    if (hsHdr) begin
                        tx_valid <= 1'b0;
                        index    <= 10'd0;
                        RamAddr  <= {bank, 12'h000};
                        state    <= RD;
                    end
                end
                RD: begin
                    if (captureStb) begin
                        tx_data  <= RamData;
                        tx_last  <= lastBank && lastIdx;
                        tx_valid <= 1'b1;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (hsOut) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        if (!lastIdx) begin
                            index   <= index + 10'd1;
                            RamAddr <= {bank, 2'b00, index + 10'd1};
                            state   <= RD;
                        end else begin
                            pending <= otherPending;
                            // Final word of the highest bank: SEL would find nothing, so finish now
                            if (lastBank) begin
                                done  <= 1'b1;
                                state <= FIN;
                            end else begin
                                state <= SEL;
                            end
                        end
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    RamAddr <= 16'h0000;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corr_bank_dump.sv
// tb/tb_corr_bank_dump.sv - self-checking bench for corr_bank_dump
module tb_corr_bank_dump;

    localparam int BUDGET = 20000;

    typedef struct {
        int          unit;
        logic [4:0]  mask;
        int          duty;
        int          restartAt;
        int          expWords;
        logic [31:0] expFirst;
        logic [31:0] expLast;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       start;
    logic [1:0][4:0]  bankMask;
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0][15:0] ramAddr;
    logic [1:0][31:0] ramData;
    logic [1:0][31:0] txData;
    logic [1:0]       txValid;
    logic [1:0]       txReady;
    logic [1:0]       txLast;

    int          checks = 0;
    int          errors = 0;
    string       tag;
    logic [32:0] expQ[$];
    logic [32:0] gotQ[$];
    vec_t        vecs[7];

    always #5 clk = ~clk;

    // Unit 0 runs with RD_LATENCY=1, unit 1 with RD_LATENCY=3; each has a pipelined mock RAM
    for (genvar g = 0; g < 2; g++) begin : gUnit
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [15:0] addrPipe[4];

        always @(posedge clk) begin
            addrPipe[0] <= ramAddr[g];
            for (int k = 1; k < 4; k++) addrPipe[k] <= addrPipe[k-1];
        end

        assign ramData[g] = {addrPipe[LAT-1], 16'h0000};

        corr_bank_dump #(.RD_LATENCY(LAT)) dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start[g]),
            .bank_mask(bankMask[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .RamAddr  (ramAddr[g]),
            .RamData  (ramData[g]),
            .tx_data  (txData[g]),
            .tx_valid (txValid[g]),
            .tx_ready (txReady[g]),
            .tx_last  (txLast[g])
        );
    end

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL [%s] %s actual=%0h required=%0h", tag, name, act, exp);
        end
    endtask

    task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        check(name, act == exp, act, exp);
    endtask

    function automatic logic rnd(input int duty);
        return int'($urandom_range(99)) < duty;
    endfunction

    // Expected stream from the bank map: header, then every word as {addr,16'h0}
    function automatic void buildModel(input logic [4:0] mask);
        expQ.delete();
        for (int b = 1; b <= 5; b++) begin
            if (mask[b-1]) begin
                int len;
                bit higher;
                len    = 32 << (b - 1);
                higher = (mask >> b) != 5'd0;
                expQ.push_back({1'b0, 8'hC0, 4'(b), 4'h0, 16'(len)});
                for (int i = 0; i < len; i++) begin
                    expQ.push_back({(!higher && i == len - 1), 4'(b), 12'(i), 16'h0000});
                end
            end
        end
    endfunction

    task automatic checkIdleOutputs(input int u);
        checkEq("busy_rst", busy[u], 0);
        checkEq("done_rst", done[u], 0);
        checkEq("addr_rst", ramAddr[u], 0);
        checkEq("data_rst", txData[u], 0);
        checkEq("valid_rst", txValid[u], 0);
        checkEq("last_rst", txLast[u], 0);
    endtask

    task automatic runDump(input vec_t v);
        int u, lat, sel, doneCyc, lastAcc, busyBad, stallBad, bankBad, holdBad, validSeen, run, firstBad;
        logic        prevStall;
        logic [31:0] prevData;
        logic        prevLast;
        logic [15:0] prevAddr;
        u = v.unit;
        lat = (u == 0) ? 1 : 3;
        buildModel(v.mask);
        gotQ.delete();
        doneCyc = -1; lastAcc = -1; busyBad = 0; stallBad = 0; bankBad = 0; holdBad = 0; validSeen = 0;

        @(posedge clk); #1;
        start[u] = 1'b1; bankMask[u] = v.mask; txReady[u] = rnd(v.duty);
        @(negedge clk);
        prevStall = 1'b0; prevData = txData[u]; prevLast = txLast[u];
        prevAddr = ramAddr[u]; run = 1;

        for (int cyc = 1; cyc < BUDGET && doneCyc < 0; cyc++) begin
            @(posedge clk); #1;
            start[u]    = (cyc == v.restartAt);
            bankMask[u] = (cyc == v.restartAt) ? 5'b11111 : v.mask;
            txReady[u]  = rnd(v.duty);
            @(negedge clk);
            if (!busy[u]) busyBad++;
            if (prevStall && (!txValid[u] || txData[u] != prevData || txLast[u] != prevLast)) stallBad++;
            if (txValid[u]) validSeen++;
            if (txValid[u] && txReady[u]) begin
                gotQ.push_back({txLast[u], txData[u]});
                lastAcc = cyc;
            end
            sel = int'(ramAddr[u][15:12]);
            if (ramAddr[u] != 16'h0 && (sel < 1 || sel > 5 || !v.mask[sel-1])) bankBad++;
            if (ramAddr[u] != prevAddr) begin
                if (prevAddr != 16'h0 && run < lat + 1) holdBad++;
                run = 1;
                prevAddr = ramAddr[u];
            end else begin
                run++;
            end
            prevStall = txValid[u] && !txReady[u];
            prevData  = txData[u];
            prevLast  = txLast[u];
            if (done[u]) doneCyc = cyc;
        end

        @(posedge clk); #1;
        start[u] = 1'b0;
        @(negedge clk);
        check("done_seen", doneCyc >= 0, doneCyc, 1);
        checkEq("busy_after", busy[u], 0);
        checkEq("done_width", done[u], 0);
        checkEq("busy_held", busyBad, 0);
        checkEq("stall_stable", stallBad, 0);
        checkEq("bank_access", bankBad, 0);
        checkEq("addr_hold", holdBad, 0);
        checkEq("word_count", gotQ.size(), v.expWords);

        firstBad = -1;
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
            if (firstBad < 0 && gotQ[i] != expQ[i]) firstBad = i;
        end
        check("stream_model", firstBad < 0,
              (firstBad < 0) ? 64'd0 : {31'd0, gotQ[firstBad]},
              (firstBad < 0) ? 64'd0 : {31'd0, expQ[firstBad]});

        if (v.expWords == 0) begin
            checkEq("done_lat_empty", doneCyc, 1);
            checkEq("no_valid", validSeen, 0);
        end else begin
            checkEq("done_lat", doneCyc, lastAcc + 1);
            checkEq("first_word", gotQ[0], {1'b0, v.expFirst});
            checkEq("last_word", gotQ[gotQ.size()-1], {1'b1, v.expLast});
        end
    endtask

    initial begin
        int hs, bad;
        // unit, mask, duty, restartAt, words, first header, last word
        vecs[0] = '{0, 5'b00001, 100, -1,  33, 32'hC0100020, 32'h101F0000};
        vecs[1] = '{0, 5'b10100, 100, -1, 642, 32'hC0300080, 32'h51FF0000};
        vecs[2] = '{1, 5'b00010,  50, -1,  65, 32'hC0200040, 32'h203F0000};
        vecs[3] = '{0, 5'b00000, 100,  1,   0, 32'h0,        32'h0};
        vecs[4] = '{0, 5'b01000, 100, 60, 257, 32'hC0400100, 32'h40FF0000};
        vecs[5] = '{1, 5'b10001,  50, 200, 546, 32'hC0100020, 32'h51FF0000};
        vecs[6] = '{0, 5'b11111,  70, -1, 997, 32'hC0100020, 32'h51FF0000};

        rst = 1'b1; start = '0; bankMask = '0; txReady = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tag = "reset";
        checkIdleOutputs(0);
        checkIdleOutputs(1);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("vec%0d", i);
            runDump(vecs[i]);
        end

        tag = "reset_mid";
        @(posedge clk); #1;
        start[0] = 1'b1; bankMask[0] = 5'b01000; txReady[0] = 1'b1;
        hs = 0;
        for (int c = 0; c < 2000 && hs < 101; c++) begin
            @(posedge clk); #1;
            start[0] = 1'b0;
            @(negedge clk);
            if (txValid[0] && txReady[0]) hs++;
        end
        checkEq("mid_progress", hs, 101);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkIdleOutputs(0);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done[0] || busy[0] || txValid[0]) bad++;
        end
        checkEq("quiet_after_rst", bad, 0);
        tag = "post_reset";
        runDump(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
